// File: rtl/mult4_4_ctrl_pkg.sv
// mult4_4_ctrl_pkg
//   Shared types and encodings for the 4x4 serial multiplier controller.
//   Holds the controller state enum, the datapath shift-select encodings,
//   the operand-half select encodings, and the step-sequencing helper.
package mult4_4_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LD,
        S_P0,
        S_P1,
        S_P2,
        S_P3,
        S_FIN
    } state_t;

    // ans_sel: shift applied to the 2x2 partial product
    localparam logic [1:0] ANS_ZERO = 2'd0;
    localparam logic [1:0] ANS_SHL4 = 2'd1;
    localparam logic [1:0] ANS_SHL2 = 2'd2;
    localparam logic [1:0] ANS_SHL0 = 2'd3;

    // Asel/Bsel: which operand half feeds the 2x2 multiplier
    localparam logic SEL_HI = 1'b0;
    localparam logic SEL_LO = 1'b1;

    // Lowest-numbered step at or after 'from' whose run flag is set,
    // or FIN when none remains. Later ifs override earlier ones so the
    // lowest qualifying step wins.
    function automatic state_t next_step(input logic [3:0] run,
                                         input logic [2:0] from);
        state_t s;
        s = S_FIN;
        if (run[3] && from <= 3'd3) s = S_P3;
        if (run[2] && from <= 3'd2) s = S_P2;
        if (run[1] && from <= 3'd1) s = S_P1;
        if (run[0] && from == 3'd0) s = S_P0;
        return s;
    endfunction

endpackage

// File: rtl/mult4_4_step_dec.sv
// mult4_4_step_dec
//   Combinational decode of one partial-product step (0..3) into the
//   datapath operand-half selects and shift select, plus a flag saying
//   whether the step contributes a non-zero partial product.
//   Step order: 0 = A lo x B lo, 1 = A hi x B lo, 2 = A lo x B hi,
//   3 = A hi x B hi.
//   Build option: MULT4_4_CTRL_SKIP_ZERO_EN -- when defined, nonzero is
//   judged from the held operands; otherwise every step is marked to run.
// Ports:
//   step     in  2  step index
//   opa/opb  in  4  held operands (only present with the skip option)
//   Asel     out 1  A half select (SEL_HI / SEL_LO)
//   Bsel     out 1  B half select (SEL_HI / SEL_LO)
//   ans_sel  out 2  shift select for this step
//   nonzero  out 1  step must run
module mult4_4_step_dec
    import mult4_4_ctrl_pkg::*;
(
    input  logic [1:0] step,
`ifdef MULT4_4_CTRL_SKIP_ZERO_EN
    input  logic [3:0] opa,
    input  logic [3:0] opb,
`endif
    output logic       Asel,
    output logic       Bsel,
    output logic [1:0] ans_sel,
    output logic       nonzero
);

    always_comb begin
        Asel = step[0] ? SEL_HI : SEL_LO;
        Bsel = step[1] ? SEL_HI : SEL_LO;
        case (step)
            2'd0:    ans_sel = ANS_SHL0;
            2'd3:    ans_sel = ANS_SHL4;
            default: ans_sel = ANS_SHL2;
        endcase
    end

`ifdef MULT4_4_CTRL_SKIP_ZERO_EN
    logic [1:0] w_ah;
    logic [1:0] w_bh;
    assign w_ah    = step[0] ? opa[3:2] : opa[1:0];
    assign w_bh    = step[1] ? opb[3:2] : opb[1:0];
    assign nonzero = (|w_ah) && (|w_bh);
`else
    assign nonzero = 1'b1;
`endif

endmodule

// File: rtl/mult4_4_ctrl.sv
// mult4_4_ctrl
//   Sequencing controller for the 4x4 serial multiplier datapath.
//   Accepts an operand pair on start (in IDLE), clears the datapath, loads
//   it, walks the four 2x2 partial-product steps, then captures the 8-bit
//   product and pulses done.
//   Build option: MULT4_4_CTRL_SKIP_ZERO_EN -- skip steps whose selected
//   A or B half is zero (latency 4..8 instead of a fixed 8).
// Ports:
//   clk       in  1  rising-edge clock
//   rst       in  1  synchronous active-low reset
//   start     in  1  request, sampled in IDLE only
//   a, b      in  4  operands, captured on the accepting edge
//   busy      out 1  high outside IDLE
//   done      out 1  one-cycle pulse, result valid from then on
//   result    out 8  registered product, held until next done
//   dp_a/dp_b out 4  held operands driving datapath in1/in2
//   dp_rst    out 1  active-high datapath clear
//   dp_out    in  8  datapath accumulator
//   Asel/Bsel out 1  operand-half selects
//   mult_sel  out 1  pass (1) or zero (0) the 2x2 product
//   ans_sel   out 2  partial-product shift select
module mult4_4_ctrl
    import mult4_4_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic [3:0] dp_a,
    output logic [3:0] dp_b,
    output logic       dp_rst,
    input  logic [7:0] dp_out,
    output logic       Asel,
    output logic       Bsel,
    output logic       mult_sel,
    output logic [1:0] ans_sel
);

    state_t     r_state;
    state_t     w_next;
    logic       r_done;
    logic [7:0] r_result;
    logic [3:0] r_dp_a;
    logic [3:0] r_dp_b;

    logic [3:0] w_asel;
    logic [3:0] w_bsel;
    logic [3:0] w_run;
    logic [1:0] w_ans [4];
    logic       w_in_step;
    logic [1:0] w_idx;

    // One decoder per step: the controls of the current step are muxed
    // out, and all four run flags feed the skip-ahead sequencing.
    for (genvar gi = 0; gi < 4; gi++) begin : g_step
        mult4_4_step_dec u_dec (
            .step    (2'(gi)),
`ifdef MULT4_4_CTRL_SKIP_ZERO_EN
            .opa     (r_dp_a),
            .opb     (r_dp_b),
`endif
            .Asel    (w_asel[gi]),
            .Bsel    (w_bsel[gi]),
            .ans_sel (w_ans[gi]),
            .nonzero (w_run[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_done   <= 1'b0;
            r_result <= '0;
            r_dp_a   <= '0;
            r_dp_b   <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == S_FIN);
            if (r_state == S_FIN) begin
                r_result <= dp_out;
            end
            if (r_state == S_IDLE && start) begin
                r_dp_a <= a;
                r_dp_b <= b;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_CLR;
            S_CLR:   w_next = S_LD;
            S_LD:    w_next = next_step(w_run, 3'd0);
            S_P0:    w_next = next_step(w_run, 3'd1);
            S_P1:    w_next = next_step(w_run, 3'd2);
            S_P2:    w_next = next_step(w_run, 3'd3);
            S_P3:    w_next = S_FIN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Moore decode of the datapath controls
    always_comb begin
        w_in_step = 1'b0;
        w_idx     = 2'd0;
        dp_rst    = 1'b0;
        case (r_state)
            S_CLR:   dp_rst = 1'b1;
            S_P0:    begin w_in_step = 1'b1; w_idx = 2'd0; end
            S_P1:    begin w_in_step = 1'b1; w_idx = 2'd1; end
            S_P2:    begin w_in_step = 1'b1; w_idx = 2'd2; end
            S_P3:    begin w_in_step = 1'b1; w_idx = 2'd3; end
            default: ;
        endcase
        mult_sel = w_in_step;
        Asel     = w_in_step ? w_asel[w_idx] : 1'b0;
        Bsel     = w_in_step ? w_bsel[w_idx] : 1'b0;
        ans_sel  = w_in_step ? w_ans[w_idx]  : ANS_ZERO;
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = r_done;
    assign result = r_result;
    assign dp_a   = r_dp_a;
    assign dp_b   = r_dp_b;

endmodule
